matrix_transfer_ctrl: RTL and testbench
=======================================

Name: matrix_transfer_ctrl

Overview:
- Sequences word transfers between the external 16-bit data memory and the matrix register bank (A/B write ports, C read port, driven by a rising-edge `done` strobe and a 6-bit `endereco`).
- One command moves a whole matrix: memory to bank for load A or load B, bank (C) to memory for store C.
- Sits between the instruction decoder and the memory/register-bank pair.
- Owns the bank strobe, so the bank sees clean, setup-respecting edges.

Parameters:
- WORDS, 13, 16-bit words per matrix (200-bit matrix, last word half used); range 1..16.
- ADDR_W, 9, memory address width.
- RD_LAT, 2, memory read latency in clocks from address to valid `mem_rdata`; range 1..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled in IDLE only
- op  in  2  00 load A, 01 load B, 10 store C, 11 illegal
- base_addr  in  ADDR_W  first memory word of the matrix
- busy  out  1  command in progress
- op_done  out  1  one-cycle pulse, command completed
- op_err  out  1  one-cycle pulse, illegal op rejected
- mem_addr  out  ADDR_W  memory address
- mem_wren  out  1  memory write enable
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- br_done  out  1  bank strobe; bank acts on its rising edge
- br_endereco  out  6  [5:4] 0=A, 1=B, 2=C; [3:0] word index
- br_data_in  out  16  word to write into A/B
- br_data_out  in  16  word read from C

Behaviour:
- All outputs are registered. Async reset (rst_n low) forces state IDLE, word index 0, and every output to 0.
- Reset mid-command abandons the command. Bank contents already written stay as-is. No op_done is issued.
- IDLE: start=1 with op 00/01/10 latches op and base_addr, clears index i, and enters LD_ISSUE (loads) or ST_SETUP (store).
- start=1 with op=11 pulses op_err for one cycle, stays IDLE and busy stays 0.
- start outside IDLE is ignored; busy=1 from the cycle after acceptance through FINISH.
- Load word loop, RD_LAT+3 cycles per word:
  - LD_ISSUE (1 cycle): mem_addr=base+i, mem_wren=0.
  - LD_WAIT (RD_LAT cycles, internal counter): on its last cycle, capture mem_rdata into br_data_in and set br_endereco={op[0]?2'b01:2'b00, i[3:0]}.
  - LD_STROBE (1 cycle): br_done=1; data and address have been stable for at least one cycle.
  - LD_RELEASE (1 cycle): br_done=0; then i+1. Go to LD_ISSUE if i+1<WORDS, else FINISH.
- Store word loop, 4 cycles per word:
  - ST_SETUP: br_endereco={2'b10,i[3:0]}.
  - ST_STROBE: br_done=1.
  - ST_RELEASE: br_done=0; the bank has updated br_data_out.
  - ST_WRITE: mem_addr=base+i, mem_wdata=br_data_out, mem_wren=1 for exactly this cycle. Then i+1, loop or FINISH.
- FINISH: op_done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Timing from the start-sampling edge to op_done high:
  - loads: WORDS*(RD_LAT+3)+1 clocks (66 at defaults);
  - store: WORDS*4+1 clocks (53).
- br_done is never high on two consecutive cycles. It always has a low cycle between pulses.
- Address arithmetic is modulo 2^ADDR_W, so base+i wraps past the top of memory without error.
- mem_wren is never asserted during loads.
- br_endereco and br_data_in hold their last values when not strobing.
- mem_addr holds its last value in IDLE.

Test Plan:
- Reset with start held: assert rst_n=0 mid-load at word 5 -> all outputs 0 immediately; IDLE on release; no op_done.
- Load A: base_addr=0x010, memory[0x010+k]=0x1100+k, k=0..12 -> 13 br_done pulses with endereco=0..12 and br_data_in=0x1100..0x110C; op_done 66 clocks after start; mem_wren never 1.
- Load B at wrap: base_addr=0x1FA -> mem_addr sequence 0x1FA..0x1FF then 0x000..0x006; endereco[5:4]=01 throughout.
- Store C: bank model returns br_data_out=0xC000+index on each strobe, base 0x080 -> 13 single-cycle writes, mem[0x080+k]=0xC000+k; op_done 53 clocks after start.
- Illegal and overlapping commands: op=11 -> op_err pulse, busy stays 0, no memory or bank activity; start pulsed during a busy load -> ignored, exactly 13 strobes.
- Strobe hygiene (assertion across all runs): br_done high never lasts more than 1 cycle; br_endereco and br_data_in are unchanged in the cycle before and during each br_done high.

Source files
------------

// File: rtl/matrix_transfer_ctrl.sv
// Moves one whole matrix between the 16-bit data memory and the A/B/C register bank.
// Loads read memory into bank A or B; a store reads bank C and writes it to memory.
module matrix_transfer_ctrl #(
  parameter int WORDS  = 13,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              op_done,
  output logic              op_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              br_done,
  output logic [5:0]        br_endereco,
  output logic [15:0]       br_data_in,
  input  logic [15:0]       br_data_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_ISSUE,
    S_LD_WAIT,
    S_LD_STROBE,
    S_LD_RELEASE,
    S_ST_SETUP,
    S_ST_STROBE,
    S_ST_RELEASE,
    S_ST_WRITE,
    S_FINISH
  } state_t;

  state_t            state_q;
  logic              sel_b_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        idx_q;
  logic [2:0]        wait_q;

  logic              busy_q;
  logic              op_done_q;
  logic              op_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wren_q;
  logic [15:0]       mem_wdata_q;
  logic              br_done_q;
  logic [5:0]        br_endereco_q;
  logic [15:0]       br_data_in_q;

  logic [4:0]        idx_d;
  logic              last_d;

  assign idx_d  = idx_q + 5'd1;
  assign last_d = (idx_d == 5'(WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_b_q       <= 1'b0;
      base_q        <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      busy_q        <= 1'b0;
      op_done_q     <= 1'b0;
      op_err_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_wdata_q   <= '0;
      br_done_q     <= 1'b0;
      br_endereco_q <= '0;
      br_data_in_q  <= '0;
    end else begin
      op_done_q  <= 1'b0;
      op_err_q   <= 1'b0;
      mem_wren_q <= 1'b0;
      // The STROBE states are the setup cycle: the registered strobe rises as
      // they end, so bank address/data are always stable a full cycle earlier.
      br_done_q  <= (state_q == S_LD_STROBE) || (state_q == S_ST_STROBE);

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op == 2'b11) begin
              op_err_q <= 1'b1;
            end else begin
              sel_b_q <= op[0];
              base_q  <= base_addr;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              if (op[1]) begin
                br_endereco_q <= {2'b10, 4'd0};
                state_q       <= S_ST_SETUP;
              end else begin
                mem_addr_q <= base_addr;
                state_q    <= S_LD_ISSUE;
              end
            end
          end
        end

        S_LD_ISSUE: begin
          wait_q  <= '0;
          state_q <= S_LD_WAIT;
        end

        S_LD_WAIT: begin
          if (wait_q == 3'(RD_LAT - 1)) begin
            br_data_in_q  <= mem_rdata;
            br_endereco_q <= {1'b0, sel_b_q, idx_q[3:0]};
            state_q       <= S_LD_STROBE;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end

        S_LD_STROBE: state_q <= S_LD_RELEASE;

        S_LD_RELEASE: begin
          idx_q <= idx_d;
          if (last_d) begin
            state_q <= S_FINISH;
          end else begin
            mem_addr_q <= base_q + ADDR_W'(idx_d);
            state_q    <= S_LD_ISSUE;
          end
        end

        S_ST_SETUP:   state_q <= S_ST_STROBE;
        S_ST_STROBE:  state_q <= S_ST_RELEASE;
        S_ST_RELEASE: state_q <= S_ST_WRITE;

        S_ST_WRITE: begin
          // br_data_out was refreshed by the strobe two cycles back.
          mem_addr_q  <= base_q + ADDR_W'(idx_q);
          mem_wdata_q <= br_data_out;
          mem_wren_q  <= 1'b1;
          idx_q       <= idx_d;
          if (last_d) begin
            state_q <= S_FINISH;
          end else begin
            br_endereco_q <= {2'b10, idx_d[3:0]};
            state_q       <= S_ST_SETUP;
          end
        end

        S_FINISH: begin
          op_done_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign op_done     = op_done_q;
  assign op_err      = op_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wren    = mem_wren_q;
  assign mem_wdata   = mem_wdata_q;
  assign br_done     = br_done_q;
  assign br_endereco = br_endereco_q;
  assign br_data_in  = br_data_in_q;

endmodule

// File: tb/tb_matrix_transfer_ctrl.sv
// Directed bench for matrix_transfer_ctrl: memory with RD_LAT pipeline, a bank C model,
// and a monitor that logs every strobe and memory write for later comparison.
module tb_matrix_transfer_ctrl;
  localparam int WORDS  = 13;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, op_done, op_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              br_done;
  logic [5:0]        br_endereco;
  logic [15:0]       br_data_in;
  logic [15:0]       br_data_out = '0;

  matrix_transfer_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base_addr(base_addr),
    .busy(busy), .op_done(op_done), .op_err(op_err),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .br_done(br_done), .br_endereco(br_endereco), .br_data_in(br_data_in),
    .br_data_out(br_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data for the address presented after edge e is readable at edge e+RD_LAT+1.
  logic [15:0] mem [512];
  logic [15:0] rd_pipe [RD_LAT];
  assign mem_rdata = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  logic [5:0]  s_end  [256];
  logic [15:0] s_din  [256];
  logic [8:0]  s_addr [256];
  logic [8:0]  w_addr [256];
  logic [15:0] w_dat  [256];
  int strb_cnt = 0, wr_cnt = 0, done_cnt = 0, hyg_cnt = 0;
  logic        prev_done = 1'b0;
  logic [5:0]  prev_end  = '0;
  logic [15:0] prev_din  = '0;

  always @(posedge clk) begin
    if (br_done) begin
      if (prev_done) hyg_cnt++;
      else begin
        if (br_endereco !== prev_end || br_data_in !== prev_din) hyg_cnt++;
        s_end[strb_cnt[7:0]]  = br_endereco;
        s_din[strb_cnt[7:0]]  = br_data_in;
        s_addr[strb_cnt[7:0]] = mem_addr;
        strb_cnt++;
        if (br_endereco[5:4] == 2'b10) br_data_out <= 16'hC000 + {12'h000, br_endereco[3:0]};
      end
    end
    if (mem_wren) begin
      w_addr[wr_cnt[7:0]] = mem_addr;
      w_dat[wr_cnt[7:0]]  = mem_wdata;
      wr_cnt++;
    end
    if (op_done) done_cnt++;
    prev_done = br_done;
    prev_end  = br_endereco;
    prev_din  = br_data_in;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command from a negedge and waits (bounded) for op_done; optionally pokes
  // start with another op while the command is busy.
  task automatic run_cmd(input logic [1:0] c_op, input logic [8:0] c_base,
                         input int intrude, output int lat);
    int  s;
    bit  found;
    found = 1'b0;
    lat   = -1;
    start = 1'b1; op = c_op; base_addr = c_base;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0; base_addr = 9'h155;
    chk_vec("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 0; k < 300 && !found; k++) begin
      if (op_done) begin
        found = 1'b1;
        lat   = cyc - s;
      end else begin
        start = (intrude != 0 && k == intrude);
        op    = 2'b10;
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk_vec("op_done_seen", 32'(found), 32'd1);
    chk_vec("busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk_vec("op_done_one_cycle", 32'(op_done), 32'd0);
  endtask

  int lat, bs, bw, bd;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'hDEAD;
    for (int k = 0; k < WORDS; k++) begin
      mem[9'h010 + k] = 16'h1100 + 16'(k);
      mem[(9'h1FA + k) % 512] = 16'hB000 + 16'(k);
    end

    // Reset with start held
    rst_n = 1'b0; start = 1'b1; op = 2'b00; base_addr = 9'h010;
    repeat (2) @(negedge clk);
    chk_vec("rst_ctrl", {24'h0, busy, op_done, op_err, br_done, mem_wren, 3'b0}, 32'h0);
    chk_vec("rst_addr", {17'h0, mem_addr, br_endereco}, 32'h0);
    chk_vec("rst_data", {mem_wdata, br_data_in}, 32'h0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_vec("idle_after_rst", 32'(busy), 32'd0);
    chk_vec("no_strobe_after_rst", 32'(strb_cnt), 32'd0);

    // Load A
    bs = strb_cnt; bw = wr_cnt;
    run_cmd(2'b00, 9'h010, 0, lat);
    chk_vec("ldA_latency", 32'(lat), 32'd66);
    chk_vec("ldA_strobes", 32'(strb_cnt - bs), 32'd13);
    chk_vec("ldA_no_wren", 32'(wr_cnt - bw), 32'd0);
    for (int k = 0; k < WORDS; k++) begin
      chk_vec($sformatf("ldA_end%0d", k), 32'(s_end[bs + k]), 32'(k));
      chk_vec($sformatf("ldA_din%0d", k), 32'(s_din[bs + k]), 32'h1100 + 32'(k));
    end

    // Load B with address wrap
    bs = strb_cnt; bw = wr_cnt;
    run_cmd(2'b01, 9'h1FA, 0, lat);
    chk_vec("ldB_latency", 32'(lat), 32'd66);
    chk_vec("ldB_strobes", 32'(strb_cnt - bs), 32'd13);
    chk_vec("ldB_no_wren", 32'(wr_cnt - bw), 32'd0);
    for (int k = 0; k < WORDS; k++) begin
      chk_vec($sformatf("ldB_addr%0d", k), 32'(s_addr[bs + k]), (32'h1FA + 32'(k)) % 32'd512);
      chk_vec($sformatf("ldB_end%0d", k), 32'(s_end[bs + k]), 32'h10 + 32'(k));
      chk_vec($sformatf("ldB_din%0d", k), 32'(s_din[bs + k]), 32'hB000 + 32'(k));
    end

    // Store C
    bs = strb_cnt; bw = wr_cnt;
    run_cmd(2'b10, 9'h080, 0, lat);
    chk_vec("stC_latency", 32'(lat), 32'd53);
    chk_vec("stC_strobes", 32'(strb_cnt - bs), 32'd13);
    chk_vec("stC_writes", 32'(wr_cnt - bw), 32'd13);
    for (int k = 0; k < WORDS; k++) begin
      chk_vec($sformatf("stC_end%0d", k), 32'(s_end[bs + k]), 32'h20 + 32'(k));
      chk_vec($sformatf("stC_waddr%0d", k), 32'(w_addr[bw + k]), 32'h080 + 32'(k));
      chk_vec($sformatf("stC_wdat%0d", k), 32'(w_dat[bw + k]), 32'hC000 + 32'(k));
    end

    // Illegal op
    bs = strb_cnt; bw = wr_cnt;
    start = 1'b1; op = 2'b11; base_addr = 9'h000;
    @(negedge clk); start = 1'b0;
    chk_vec("ill_err_pulse", 32'(op_err), 32'd1);
    chk_vec("ill_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk_vec("ill_err_one_cycle", 32'(op_err), 32'd0);
    repeat (10) @(negedge clk);
    chk_vec("ill_quiet", {busy, 7'h0, 8'(strb_cnt - bs), 8'(wr_cnt - bw), 8'h0}, 32'h0);

    // Start during a busy load is ignored
    bs = strb_cnt; bw = wr_cnt;
    run_cmd(2'b00, 9'h010, 12, lat);
    chk_vec("ovl_latency", 32'(lat), 32'd66);
    chk_vec("ovl_strobes", 32'(strb_cnt - bs), 32'd13);
    chk_vec("ovl_no_wren", 32'(wr_cnt - bw), 32'd0);

    // Reset in the middle of a load
    bs = strb_cnt; bd = done_cnt;
    start = 1'b1; op = 2'b00; base_addr = 9'h010;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 200 && (strb_cnt - bs) < 5; k++) @(negedge clk);
    chk_vec("mid_reached_word5", 32'(strb_cnt - bs), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_vec("mid_rst_ctrl", {27'h0, busy, op_done, op_err, br_done, mem_wren}, 32'h0);
    chk_vec("mid_rst_addr", {17'h0, mem_addr, br_endereco}, 32'h0);
    chk_vec("mid_rst_data", {mem_wdata, br_data_in}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk_vec("mid_no_done", 32'(done_cnt - bd), 32'd0);
    chk_vec("mid_idle", 32'(busy), 32'd0);
    chk_vec("mid_strobes", 32'(strb_cnt - bs), 32'd5);

    chk_vec("strobe_hygiene", 32'(hyg_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
